// File: rtl/etapa_if.sv
// etapa_if: instruction-fetch stage between the PC counter and IF/ID.
// Req/ack fetch, one-entry skid buffer on stall, flush, align/timeout traps.
module etapa_if #(
    parameter logic [31:0] NOP      = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] PC,
    input  logic        Stall,
    input  logic        Flush,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] PCMC,
    output logic        en,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        ErrAlign,
    output logic        ErrTimeout
);

    typedef enum logic [1:0] {
        INICIO,
        PIDE,
        ESPERA,
        FALLA
    } estado_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);

    estado_t     state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        erra_q, erra_d;
    logic        errt_q, errt_d;
    logic        xfer;
    logic [31:0] xfer_word;
    logic [31:0] xfer_pc4;

    assign PCMC       = PC + 32'd4;
    assign IMemAddr   = PC;
    assign InstrD     = instr_q;
    assign PCPlus4D   = pc4_q;
    assign ValidD     = valid_q;
    assign ErrAlign   = erra_q;
    assign ErrTimeout = errt_q;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        erra_d      = erra_q;
        errt_d      = errt_q;
        IMemReq     = 1'b0;
        en          = 1'b0;
        xfer        = 1'b0;
        xfer_word   = NOP;
        xfer_pc4    = pc4_q;
        unique case (state_q)
            INICIO: state_d = PIDE;
            PIDE: begin
                if (PC[1:0] != 2'b00) begin
                    erra_d  = 1'b1;
                    state_d = FALLA;
                end else begin
                    IMemReq = 1'b1;
                    if (IMemAck) begin
                        wait_d = 8'd0;
                        if (Flush) begin
                            en = 1'b1;
                        end else if (!Stall) begin
                            en        = 1'b1;
                            xfer      = 1'b1;
                            xfer_word = IMemData;
                            xfer_pc4  = PCMC;
                        end else begin
                            buf_instr_d = IMemData;
                            buf_pc4_d   = PCMC;
                            state_d     = ESPERA;
                        end
                    end else if (wait_q == WAIT_LIM) begin
                        errt_d  = 1'b1;
                        state_d = FALLA;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            ESPERA: begin
                // A flush simply abandons the buffered word.
                if (Flush) begin
                    en      = 1'b1;
                    state_d = PIDE;
                end else if (!Stall) begin
                    en        = 1'b1;
                    xfer      = 1'b1;
                    xfer_word = buf_instr_q;
                    xfer_pc4  = buf_pc4_q;
                    state_d   = PIDE;
                end
            end
            FALLA: state_d = FALLA;
            default: state_d = INICIO;
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (Flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (Stall) begin
            instr_d = instr_q;
        end else if (xfer) begin
            instr_d = xfer_word;
            pc4_d   = xfer_pc4;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= INICIO;
            wait_q      <= 8'd0;
            buf_instr_q <= NOP;
            buf_pc4_q   <= 32'd0;
            instr_q     <= NOP;
            pc4_q       <= 32'd0;
            valid_q     <= 1'b0;
            erra_q      <= 1'b0;
            errt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            erra_q      <= erra_d;
            errt_q      <= errt_d;
        end
    end

endmodule

// File: tb/tb_etapa_if.sv
// Scoreboard bench for etapa_if: directed fetch sequences, IF/ID loads
// checked by a monitor, control outputs checked per cycle.
module tb_etapa_if;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PC = 32'd0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = 32'd0;
    logic [31:0] PCMC;
    logic        en;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        ErrAlign;
    logic        ErrTimeout;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    etapa_if dut (
        .CLK(CLK),
        .Reset(Reset),
        .PC(PC),
        .Stall(Stall),
        .Flush(Flush),
        .IMemReq(IMemReq),
        .IMemAddr(IMemAddr),
        .IMemAck(IMemAck),
        .IMemData(IMemData),
        .PCMC(PCMC),
        .en(en),
        .InstrD(InstrD),
        .PCPlus4D(PCPlus4D),
        .ValidD(ValidD),
        .ErrAlign(ErrAlign),
        .ErrTimeout(ErrTimeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every fresh IF/ID load must match the head of the queue.
    always @(posedge CLK) begin
        logic st;
        logic [63:0] e;
        st = Stall;
        #1;
        if (!Reset && !st && ValidD) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL ifid_unexpected: got %h/%h expected none",
                         InstrD, PCPlus4D);
            end else begin
                e = exp_q.pop_front();
                chk("ifid", {InstrD, PCPlus4D}, e);
            end
        end
    end

    // Drive one cycle, check combinational outputs, return after the edge.
    task automatic cyc(input logic [31:0] pc, input logic ack,
                       input logic [31:0] data, input logic st,
                       input logic fl, input logic x_en,
                       input logic x_req);
        @(negedge CLK);
        PC = pc;
        IMemAck = ack;
        IMemData = data;
        Stall = st;
        Flush = fl;
        #1;
        chk("en", {63'd0, en}, {63'd0, x_en});
        chk("req", {63'd0, IMemReq}, {63'd0, x_req});
        chk("addr", {32'd0, IMemAddr}, {32'd0, pc});
        chk("pcmc", {32'd0, PCMC}, {32'd0, pc + 32'd4});
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        IMemAck = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_instr", {32'd0, InstrD}, 64'd0);
        chk("rst_pc4", {32'd0, PCPlus4D}, 64'd0);
        chk("rst_valid", {63'd0, ValidD}, 64'd0);
        chk("rst_req", {63'd0, IMemReq}, 64'd0);
        chk("rst_en", {63'd0, en}, 64'd0);
        chk("rst_err", {62'd0, ErrAlign, ErrTimeout}, 64'd0);
        Reset = 1'b0;
    endtask

    initial begin
        do_reset();
        // INICIO cycle: ack ignored, no request
        cyc(32'h0, 1, 32'h11, 0, 0, 0, 0);
        // zero-wait stream
        exp_q.push_back({32'h11, 32'h4});
        cyc(32'h0, 1, 32'h11, 0, 0, 1, 1);
        exp_q.push_back({32'h22, 32'h8});
        cyc(32'h4, 1, 32'h22, 0, 0, 1, 1);
        exp_q.push_back({32'h33, 32'hC});
        cyc(32'h8, 1, 32'h33, 0, 0, 1, 1);
        // three wait states then ack
        for (int i = 0; i < 3; i++)
            cyc(32'h70, 0, 32'h0, 0, 0, 0, 1);
        chk("wait_bubble", {63'd0, ValidD}, 64'd0);
        exp_q.push_back({32'hABCD, 32'h74});
        cyc(32'h70, 1, 32'hABCD, 0, 0, 1, 1);
        // stall at ack, two cycles
        cyc(32'h74, 1, 32'h5555, 1, 0, 0, 1);
        chk("stall_hold1", {32'd0, InstrD}, {32'd0, 32'hABCD});
        cyc(32'h74, 0, 32'h0, 1, 0, 0, 0);
        chk("stall_hold2", {32'd0, InstrD}, {32'd0, 32'hABCD});
        exp_q.push_back({32'h5555, 32'h78});
        cyc(32'h74, 0, 32'h0, 0, 0, 1, 0);
        exp_q.push_back({32'h66, 32'h7C});
        cyc(32'h78, 1, 32'h66, 0, 0, 1, 1);
        // flush while the skid buffer is full
        cyc(32'h7C, 1, 32'h77, 1, 0, 0, 1);
        cyc(32'h7C, 0, 32'h0, 0, 1, 1, 0);
        chk("fl_esp_instr", {32'd0, InstrD}, 64'd0);
        chk("fl_esp_valid", {63'd0, ValidD}, 64'd0);
        exp_q.push_back({32'h88, 32'h204});
        cyc(32'h200, 1, 32'h88, 0, 0, 1, 1);
        // flush on the ack cycle
        cyc(32'h204, 1, 32'h99, 0, 1, 1, 1);
        chk("fl_ack_valid", {63'd0, ValidD}, 64'd0);
        chk("fl_ack_instr", {32'd0, InstrD}, 64'd0);
        exp_q.push_back({32'hAA, 32'h304});
        cyc(32'h300, 1, 32'hAA, 0, 0, 1, 1);
        // flush beats stall on ack
        cyc(32'h304, 1, 32'hBB, 1, 1, 1, 1);
        chk("fl_st_valid", {63'd0, ValidD}, 64'd0);
        // PC+4 wraps at the top of the address space
        exp_q.push_back({32'hCC, 32'h0});
        cyc(32'hFFFF_FFFC, 1, 32'hCC, 0, 0, 1, 1);
        chk("wrap_noerr", {62'd0, ErrAlign, ErrTimeout}, 64'd0);
        chk("q_empty1", 64'(exp_q.size()), 64'd0);

        // misaligned PC
        do_reset();
        cyc(32'h6, 1, 32'hDEAD, 0, 0, 0, 0);
        cyc(32'h6, 1, 32'hDEAD, 0, 0, 0, 0);
        chk("align_err", {63'd0, ErrAlign}, 64'd1);
        for (int i = 0; i < 3; i++)
            cyc(32'h0, 1, 32'hDEAD, 0, 0, 0, 0);
        chk("align_stuck", {63'd0, ErrAlign}, 64'd1);
        chk("align_valid", {63'd0, ValidD}, 64'd0);
        chk("align_noto", {63'd0, ErrTimeout}, 64'd0);

        // timeout after MAX_WAIT request cycles
        do_reset();
        cyc(32'h40, 0, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(32'h40, 0, 32'h0, 0, 0, 0, 1);
            chk("to_flag", {63'd0, ErrTimeout}, {63'd0, i == 14});
        end
        for (int i = 0; i < 3; i++)
            cyc(32'h40, 1, 32'h1234, 0, 0, 0, 0);
        chk("to_valid", {63'd0, ValidD}, 64'd0);
        chk("to_sticky", {63'd0, ErrTimeout}, 64'd1);
        chk("q_empty2", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
